// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table checker and the benches that drive it.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        DONE
    } tt_state_e;

    localparam int DEFAULT_VARS = 4;

    // var_num 0 is input a, the most significant bit of the vector index.
    function automatic logic tt_index_bit(input int unsigned idx,
                                          input int unsigned var_num,
                                          input int unsigned vars = DEFAULT_VARS);
        logic [31:0] shifted;
        shifted = idx >> (vars - 1 - var_num);
        return shifted[0];
    endfunction

endpackage

// File: rtl/tt_settle_counter.sv
// Hold-window down-counter: expire marks the last cycle of the current settle window.
module tt_settle_counter #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic extend,
    input  logic count_en,
    output logic expire
);

    localparam int CW = $clog2(SETTLE + 2);

    logic [CW-1:0] cnt;

    // extend adds the entry cycle spent in APPLY right after an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(SETTLE) + CW'(extend);
        end else if (count_en && !expire) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expire = (cnt <= CW'(1));

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps every input vector into a combinational DUT and scores dut_y against an expected table.
//
// state  | meaning
// IDLE   | waiting for start after reset
// APPLY  | vector on dut_in, waiting for the settle window to expire
// SAMPLE | capture dut_y for the current vector, advance or finish
// DONE   | results valid and held until the next start
module truth_table_checker
    import tt_pkg::*;
#(
    parameter int VARS   = DEFAULT_VARS,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2**VARS-1:0]   expected,
    output logic [VARS-1:0]      dut_in,
    input  logic                 dut_y,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [VARS:0]        err_count,
    output logic                 fail_valid,
    output logic [VARS-1:0]      first_fail,
    output logic [2**VARS-1:0]   observed
);

    localparam int N  = 2 ** VARS;
    localparam int EW = VARS + 1;

    tt_state_e       state;
    logic [N-1:0]    expected_q;
    logic [VARS-1:0] idx;

    logic idle_like;
    logic last;
    logic sample_bad;
    logic settle_load;
    logic settle_extend;
    logic settle_expire;

    assign idle_like     = (state == IDLE) || (state == DONE);
    assign last          = (idx == VARS'(N - 1));
    // Case inequality so an X or Z on dut_y is scored as a mismatch.
    assign sample_bad    = (dut_y !== expected_q[idx]);
    assign settle_load   = (idle_like && start) || ((state == SAMPLE) && !last);
    assign settle_extend = idle_like;

    tt_settle_counter #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (settle_load),
        .extend   (settle_extend),
        .count_en (state == APPLY),
        .expire   (settle_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            expected_q <= '0;
            idx        <= '0;
            dut_in     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
            observed   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        expected_q <= expected;
                        idx        <= '0;
                        dut_in     <= '0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        first_fail <= '0;
                        observed   <= '0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        state      <= APPLY;
                    end
                end
                APPLY: begin
                    if (settle_expire) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    observed[idx] <= (dut_y === 1'b1);
                    if (sample_bad) begin
                        err_count <= err_count + EW'(1);
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            first_fail <= idx;
                        end
                    end
                    if (last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !sample_bad;
                        state <= DONE;
                    end else begin
                        idx    <= idx + VARS'(1);
                        dut_in <= idx + VARS'(1);
                        // With no settle time the next vector is sampled on the very next edge.
                        state  <= (SETTLE == 0) ? SAMPLE : APPLY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Randomized scoreboard bench for truth_table_checker with SETTLE=1 (inst a) and SETTLE=0 (inst b).
module tb_truth_table_checker;
    import tt_pkg::*;

    localparam int VARS = 4;
    localparam int N    = 16;
    localparam int EW   = VARS + 1;

    typedef struct {
        logic [N-1:0]    observed;
        logic [EW-1:0]   err_count;
        logic            fail_valid;
        logic [VARS-1:0] first_fail;
        logic            pass;
        int              latency;
        int              start_cyc;
    } result_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic          xval;
    logic [N-1:0]  and_or;
    logic [N-1:0]  rnd_lut;
    logic [N-1:0]  rnd_exp;

    // instance a: SETTLE = 1, with fault modes on the modelled DUT
    logic            start_a = 1'b0;
    logic [N-1:0]    exp_a   = '0;
    logic [VARS-1:0] dut_in_a;
    logic            dut_y_a;
    logic            busy_a, done_a, pass_a, fv_a;
    logic [EW-1:0]   err_a;
    logic [VARS-1:0] ff_a;
    logic [N-1:0]    obs_a;
    logic [N-1:0]    lut_a  = '0;
    logic            tie0_a = 1'b0;
    logic            x5_a   = 1'b0;

    // instance b: SETTLE = 0
    logic            start_b = 1'b0;
    logic [N-1:0]    exp_b   = '0;
    logic [VARS-1:0] dut_in_b;
    logic            dut_y_b;
    logic            busy_b, done_b, pass_b, fv_b;
    logic [EW-1:0]   err_b;
    logic [VARS-1:0] ff_b;
    logic [N-1:0]    obs_b;
    logic [N-1:0]    lut_b = '0;

    result_t q_a[$];
    result_t q_b[$];

    truth_table_checker #(.VARS(VARS), .SETTLE(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .expected(exp_a),
        .dut_in(dut_in_a), .dut_y(dut_y_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(err_a), .fail_valid(fv_a),
        .first_fail(ff_a), .observed(obs_a)
    );

    truth_table_checker #(.VARS(VARS), .SETTLE(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .expected(exp_b),
        .dut_in(dut_in_b), .dut_y(dut_y_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_b), .fail_valid(fv_b),
        .first_fail(ff_b), .observed(obs_b)
    );

    // Modelled combinational DUTs: a lookup table plus optional faults.
    always_comb begin
        dut_y_a = tie0_a ? 1'b0 : lut_a[dut_in_a];
        if (x5_a && dut_in_a == 4'd5) dut_y_a = xval;
    end

    always_comb begin
        dut_y_b = lut_b[dut_in_b];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, req, $time);
        end
    endtask

    // Reference: walk every vector index, score the value the modelled DUT drives.
    function automatic result_t ref_sweep(input logic [N-1:0] exp, input logic [N-1:0] lut,
                                          input logic tie0, input logic x5,
                                          input logic xv, input int settle);
        result_t r;
        logic    y;
        int      errs;
        errs         = 0;
        r.observed   = '0;
        r.fail_valid = 1'b0;
        r.first_fail = '0;
        for (int i = 0; i < N; i++) begin
            y = tie0 ? 1'b0 : lut[i];
            if (x5 && i == 5) y = xv;
            r.observed[i] = (y === 1'b1);
            if (y !== exp[i]) begin
                errs++;
                if (!r.fail_valid) begin
                    r.fail_valid = 1'b1;
                    r.first_fail = VARS'(i);
                end
            end
        end
        r.err_count = EW'(errs);
        r.pass      = (errs == 0);
        r.latency   = N * (settle + 1) + 1;
        r.start_cyc = 0;
        return r;
    endfunction

    task automatic sweep_a(input logic [N-1:0] exp, input logic [N-1:0] lut,
                           input logic tie0, input logic x5);
        result_t r;
        lut_a  = lut;
        tie0_a = tie0;
        x5_a   = x5;
        exp_a  = exp;
        r = ref_sweep(exp, lut, tie0, x5, xval, 1);
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        r.start_cyc = cyc;
        q_a.push_back(r);
        chk("a_start_busy", busy_a, 1);
        chk("a_start_done_clr", done_a, 0);
        chk("a_start_err_clr", err_a, 0);
        exp_a = N'($urandom);
    endtask

    task automatic sweep_b(input logic [N-1:0] exp, input logic [N-1:0] lut);
        result_t r;
        lut_b = lut;
        exp_b = exp;
        r = ref_sweep(exp, lut, 1'b0, 1'b0, xval, 0);
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        r.start_cyc = cyc;
        q_b.push_back(r);
        chk("b_start_busy", busy_b, 1);
        exp_b = N'($urandom);
    endtask

    task automatic drain(input int which, input int budget);
        int n;
        n = 0;
        while (((which == 0) ? q_a.size() : q_b.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (((which == 0) ? q_a.size() : q_b.size()) != 0) begin
            errors++;
            $display("FAIL drain_%0d: done not seen within %0d cycles, required a completed sweep",
                     which, budget);
            q_a.delete();
            q_b.delete();
        end
    endtask

    task automatic chk_reset_a();
        chk("rst_dut_in", dut_in_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_err_count", err_a, 0);
        chk("rst_fail_valid", fv_a, 0);
        chk("rst_first_fail", ff_a, 0);
        chk("rst_observed", obs_a, 0);
    endtask

    // Result monitors: pop on the rising edge of done.
    logic    done_a_q = 1'b0;
    logic    done_b_q = 1'b0;
    result_t e_a, e_b;

    always @(negedge clk) begin
        if (done_a && !done_a_q) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_done: got done=1, required no sweep pending");
            end else begin
                e_a = q_a.pop_front();
                chk("a_pass", pass_a, e_a.pass);
                chk("a_err_count", err_a, e_a.err_count);
                chk("a_fail_valid", fv_a, e_a.fail_valid);
                if (e_a.fail_valid) chk("a_first_fail", ff_a, e_a.first_fail);
                chk("a_observed", obs_a, e_a.observed);
                chk("a_latency", cyc - e_a.start_cyc, e_a.latency);
                chk("a_busy_done", busy_a, 0);
                chk("a_dut_in_hold", dut_in_a, N - 1);
            end
        end
        done_a_q <= done_a;
    end

    always @(negedge clk) begin
        if (done_b && !done_b_q) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_done: got done=1, required no sweep pending");
            end else begin
                e_b = q_b.pop_front();
                chk("b_pass", pass_b, e_b.pass);
                chk("b_err_count", err_b, e_b.err_count);
                chk("b_fail_valid", fv_b, e_b.fail_valid);
                if (e_b.fail_valid) chk("b_first_fail", ff_b, e_b.first_fail);
                chk("b_observed", obs_b, e_b.observed);
                chk("b_latency", cyc - e_b.start_cyc, e_b.latency);
            end
        end
        done_b_q <= done_b;
    end

    // Hold-time monitors: vector 0 also carries the entry cycle after start.
    logic [VARS-1:0] last_in_a = '0, last_in_b = '0;
    logic            prev_busy_a = 1'b0, prev_busy_b = 1'b0;
    int              run_a = 0, run_b = 0;

    always @(negedge clk) begin
        if (busy_a && !prev_busy_a) begin
            run_a = 1;
        end else if (busy_a && dut_in_a != last_in_a) begin
            chk("a_hold_cycles", run_a, (last_in_a == 0) ? 3 : 2);
            run_a = 1;
        end else if (busy_a) begin
            run_a++;
        end
        last_in_a   = dut_in_a;
        prev_busy_a = busy_a;
    end

    always @(negedge clk) begin
        if (busy_b && !prev_busy_b) begin
            run_b = 1;
        end else if (busy_b && dut_in_b != last_in_b) begin
            chk("b_hold_cycles", run_b, (last_in_b == 0) ? 2 : 1);
            run_b = 1;
        end else if (busy_b) begin
            run_b++;
        end
        last_in_b   = dut_in_b;
        prev_busy_b = busy_b;
    end

    initial begin
        logic probe;
        int   n;
        probe = 1'bx;
        // On a two-state simulator an unknown cannot be driven; a wrong 1 stands in.
        xval = $isunknown(probe) ? 1'bx : 1'b1;
        for (int i = 0; i < N; i++) begin
            and_or[i] = (tt_index_bit(i, 0) & tt_index_bit(i, 1)) |
                        (tt_index_bit(i, 2) & tt_index_bit(i, 3));
        end

        repeat (3) @(negedge clk);
        chk_reset_a();
        chk("rst_b_busy", busy_b, 0);
        chk("rst_b_err_count", err_b, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        sweep_a(and_or, and_or, 1'b0, 1'b0);
        drain(0, 100);
        sweep_a(and_or ^ 16'h0004, and_or, 1'b0, 1'b0);
        drain(0, 100);
        sweep_a(16'hFFFF, and_or, 1'b1, 1'b0);
        drain(0, 100);
        sweep_a(and_or, and_or, 1'b0, 1'b1);
        drain(0, 100);
        sweep_a(and_or, and_or, 1'b0, 1'b0);
        drain(0, 100);

        sweep_b(and_or, and_or);
        repeat (6) @(negedge clk);
        start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        chk("b_busy_ignores_start", busy_b, 1);
        drain(1, 100);

        sweep_a(and_or, and_or, 1'b0, 1'b0);
        n = 0;
        while (dut_in_a != 4'd7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("a_reach_vector7", dut_in_a, 7);
        #2 rst_n = 1'b0;
        #1 chk_reset_a();
        q_a.delete();
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        sweep_a(and_or, and_or, 1'b0, 1'b0);
        drain(0, 100);

        for (int k = 0; k < 10; k++) begin
            rnd_lut = N'($urandom);
            case ($urandom_range(2, 0))
                0:       rnd_exp = rnd_lut;
                1:       rnd_exp = rnd_lut ^ (N'(1) << $urandom_range(N - 1, 0));
                default: rnd_exp = N'($urandom);
            endcase
            sweep_a(rnd_exp, rnd_lut, ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0));
            drain(0, 100);
        end
        for (int k = 0; k < 6; k++) begin
            rnd_lut = N'($urandom);
            rnd_exp = ($urandom_range(1, 0) == 0) ? rnd_lut : N'($urandom);
            sweep_b(rnd_exp, rnd_lut);
            drain(1, 100);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Response-side counterpart to the lab exhaustive-stimulus benches: the checker drives all 2^VARS input vectors into a combinational expression DUT.
- Samples the DUT's single output `dut_y` for each vector and compares it against an expected truth table.
- Reports pass/fail, mismatch count, the first failing index and the captured observed table.
- Sits beside the DUT in synthesizable self-test wrappers, replacing $display/VCD inspection.

Parameters:
- VARS, 4, number of DUT inputs; vector index i is driven with bit VARS-1 (input a) as MSB.
- SETTLE, 1, extra cycles each vector is held before sampling (0 allowed).
- N = 2**VARS, derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a sweep; honoured only when not busy
- expected  in  N  expected truth table, bit i = expected y for vector i; latched on accepted start
- dut_in  out  VARS  vector applied to DUT
- dut_y  in  1  DUT output
- busy  out  1  sweep in progress
- done  out  1  sweep complete; held until next accepted start
- pass  out  1  valid when done: err_count == 0
- err_count  out  VARS+1  number of mismatching vectors (0..N)
- fail_valid  out  1  at least one mismatch recorded this sweep
- first_fail  out  VARS  index of first mismatch; meaningful only when fail_valid
- observed  out  N  captured dut_y per index

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0: dut_in, busy, done, pass, err_count, fail_valid, first_fail, observed. Internal expected_q, idx and settle counter are also 0.
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- IDLE/DONE + start:
  - Latch expected into expected_q; clear idx, err_count, fail_valid, first_fail, observed, done and pass.
  - Drive dut_in = 0, set busy, go to APPLY.
- start while busy is ignored. start in DONE restarts the sweep.
- APPLY: count SETTLE cycles with dut_in = idx stable, then go to SAMPLE. With SETTLE = 0, go to SAMPLE on the next cycle.
- SAMPLE (one cycle):
  - observed[idx] <= dut_y.
  - Mismatch when dut_y !== expected_q[idx]; X/Z on dut_y counts as a mismatch and is captured as 0.
  - On mismatch: err_count += 1. If fail_valid is 0, set it and capture first_fail = idx.
  - If idx == N-1: go to DONE.
  - Else: idx += 1, update dut_in the same edge, go to APPLY.
- Each vector is therefore held SETTLE+1 cycles. done rises N*(SETTLE+1)+1 cycles after the accepted start edge.
- DONE: busy = 0, done = 1, pass = (err_count == 0). dut_in holds N-1. Results stay stable until the next accepted start.
- err_count width VARS+1, so an all-mismatch sweep yields exactly N with no wrap. idx does not wrap; the terminal compare is at N-1.
- A mid-sweep reset aborts immediately to reset values. No partial results are retained.
- Changes to expected during a sweep have no effect.

Decomposition:
- Shared package tt_pkg holds:
  - The state enum (IDLE, APPLY, SAMPLE, DONE).
  - DEFAULT_VARS = 4.
  - A function tt_index_bit(idx, var) returning the bit of input var for vector idx. Benches use it to map a/b/c/d.
- One natural sub-module, tt_settle_counter: loadable down-counter that asserts expire after SETTLE cycles, with expire immediate when SETTLE = 0.
- The FSM, index counter and result registers stay in truth_table_checker.

Test Plan:
- DUT model y = a&b | c&d, expected = 16'hF888, SETTLE = 1, pulse start → done after 33 cycles; pass = 1, err_count = 0, fail_valid = 0, observed = 16'hF888.
- Same DUT, expected = 16'hF88C (bit 2 wrong) → pass = 0, err_count = 1, fail_valid = 1, first_fail = 2, observed = 16'hF888.
- dut_y tied 0, expected = 16'hFFFF → err_count = 16 (5'b10000, no wrap), first_fail = 0, observed = 16'h0000.
- SETTLE = 0 with the first DUT → each dut_in value held exactly 1 cycle; done 17 cycles after start; pass = 1. Also pulse start while busy → no restart, same timing.
- Assert rst_n = 0 at vector 7 mid-sweep → all outputs 0 asynchronously, state IDLE. New start after release → full clean sweep, pass = 1.
- dut_y driven X for vector 5 only, expected = 16'hF888 → err_count = 1, first_fail = 5, observed bit 5 = 0. Then start again from DONE with correct DUT → results cleared, pass = 1.
